// File: rtl/fsm_timer_if.sv
// Control/status bundle between a client FSM and the interval timer.
// Latency: n/a (wires only).
// Backpressure: none; the timer samples every control input on every clock.
interface fsm_timer_if #(
  parameter int WIDTH = 8
) ();

  // Requests from the client
  logic             go;
  logic             abort;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] load_val;

  // Status back from the timer
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tick;

  // Client side: issues requests, observes status
  modport master (
    output go,
    output abort,
    output pause,
    output mode,
    output load_val,
    input  count,
    input  busy,
    input  done,
    input  tick
  );

  // Timer side: consumes requests, drives status
  modport slave (
    input  go,
    input  abort,
    input  pause,
    input  mode,
    input  load_val,
    output count,
    output busy,
    output done,
    output tick
  );

endinterface

// File: rtl/fsm_timer.sv
// Programmable interval timer: one-shot or periodic, with pause/resume, abort and restart.
// Latency: go -> done is T+1 cycles (one-shot); tick period T+1 (periodic); each pause episode adds high-cycles+1.
// Backpressure: none; go is ignored while busy, all outputs are registers updated with the state.
module fsm_timer #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  fsm_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] term_r;   // latched terminal value T
  logic             mode_r;   // latched mode M: 1 = periodic
  logic             busy_r;
  logic             done_r;
  logic             tick_r;

  // Terminal compare is on the current count, so all-ones is caught before
  // the increment could ever wrap.
  logic at_term;
  assign at_term = (count_r == term_r);

  // Status outputs are the registers themselves: no decode lag behind state.
  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.tick  = tick_r;

  // One FSM: state, counter, latched T/M and status flags all move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_r <= '0;
      term_r  <= '0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      // tick is a single-cycle strobe unless re-armed below
      tick_r <= 1'b0;

      case (state)
        IDLE: begin
          count_r <= '0;
          // abort has no meaning here; only go leaves IDLE
          if (bus.go) begin
            term_r  <= bus.load_val;
            mode_r  <= bus.mode;
            state   <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (bus.pause) begin
            // count holds; busy stays high through the pause
            state <= PAUSE;
          end else if (at_term) begin
            tick_r <= 1'b1;
            if (mode_r) begin
              // periodic: reload is the only way the count returns to zero
              count_r <= '0;
            end else begin
              // one-shot: park at T with done raised on this very edge
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end else begin
            count_r <= count_r + ONE;
          end
        end

        PAUSE: begin
          if (bus.abort) begin
            state   <= IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (!bus.pause) begin
            // resume costs one cycle: count holds on the edge back into RUN
            state <= RUN;
          end
        end

        DONE: begin
          if (bus.abort) begin
            state   <= IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (bus.go) begin
            // restart picks up fresh T and M
            term_r  <= bus.load_val;
            mode_r  <= bus.mode;
            count_r <= '0;
            state   <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          count_r <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_timer.sv
// Self-checking bench for fsm_timer: directed plan plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsm_timer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fsm_timer_if #(.WIDTH(W)) bus ();

  fsm_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model, kept as "what is the timer doing" rather than a state code:
  // active = timing an interval, held = frozen by pause, parked = finished one-shot.
  logic         mdl_active, mdl_held, mdl_parked, mdl_tick, mdl_periodic;
  int unsigned  mdl_cnt, mdl_limit;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    mdl_active   = 1'b0;
    mdl_held     = 1'b0;
    mdl_parked   = 1'b0;
    mdl_tick     = 1'b0;
    mdl_periodic = 1'b0;
    mdl_cnt      = 0;
    mdl_limit    = 0;
  endtask

  task automatic mdl_start(input logic md, input logic [W-1:0] lv);
    mdl_limit    = lv;
    mdl_periodic = md;
    mdl_cnt      = 0;
    mdl_active   = 1'b1;
    mdl_held     = 1'b0;
    mdl_parked   = 1'b0;
  endtask

  task automatic mdl_edge(input logic r, g, a, p, md, input logic [W-1:0] lv);
    mdl_tick = 1'b0;
    if (r) begin
      mdl_clear();
    end else if (a && (mdl_active || mdl_parked)) begin
      mdl_active = 1'b0;
      mdl_held   = 1'b0;
      mdl_parked = 1'b0;
      mdl_cnt    = 0;
    end else if (!mdl_active) begin
      if (g) mdl_start(md, lv);
    end else if (mdl_held) begin
      if (!p) mdl_held = 1'b0;
    end else if (p) begin
      mdl_held = 1'b1;
    end else if (mdl_cnt == mdl_limit) begin
      mdl_tick = 1'b1;
      if (mdl_periodic) mdl_cnt = 0;
      else begin
        mdl_active = 1'b0;
        mdl_parked = 1'b1;
      end
    end else begin
      mdl_cnt = (mdl_cnt + 1) % (1 << W);
    end
  endtask

  // One clock: drive on the falling edge, advance model on the rising edge, compare 1 time unit later.
  task automatic step(input logic r, g, a, p, md, input logic [W-1:0] lv);
    @(negedge clk);
    rst          = r;
    bus.go       = g;
    bus.abort    = a;
    bus.pause    = p;
    bus.mode     = md;
    bus.load_val = lv;
    @(posedge clk);
    mdl_edge(r, g, a, p, md, lv);
    #1;
    chk("count", int'(bus.count), int'(mdl_cnt));
    chk("busy",  int'(bus.busy),  int'(mdl_active));
    chk("done",  int'(bus.done),  int'(mdl_parked));
    chk("tick",  int'(bus.tick),  int'(mdl_tick));
  endtask

  // Quiet cycle; mode/load_val are noise that must have no effect.
  task automatic idle();
    logic [W-1:0] junk;
    junk = W'($urandom);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), junk);
  endtask

  task automatic start(input logic md, input logic [W-1:0] lv);
    step(1'b0, 1'b1, 1'b0, 1'b0, md, lv);
  endtask

  // Cycles after the start edge until done is seen; -1 if the budget expires.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      idle();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ticks;
    logic [W-1:0] t;

    mdl_clear();
    bus.go = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0; bus.mode = 1'b0; bus.load_val = '0;

    // Reset values
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_flags", int'({bus.busy, bus.done, bus.tick}), 0);
    idle();

    // One-shot T=3: done after T+1 edges, then parked at T
    start(1'b0, 8'd3);
    wait_done(20, lat);
    chk("oneshot_lat", lat, 4);
    chk("oneshot_tick", int'(bus.tick), 1);
    for (int i = 0; i < 10; i++) idle();
    chk("oneshot_park_count", int'(bus.count), 3);
    chk("oneshot_park_done", int'(bus.done), 1);

    // Restart from DONE into periodic T=2: tick every 3 edges
    start(1'b1, 8'd2);
    chk("restart_count", int'(bus.count), 0);
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (bus.tick) begin
        ticks++;
        chk("periodic_phase", i % 3, 0);
      end
    end
    chk("periodic_ticks", ticks, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Pause: T=5, pause high 3 cycles from count=2 -> done at 6 + (3+1)
    start(1'b0, 8'd5);
    idle(); idle();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    wait_done(20, lat);
    chk("pause_lat", lat + 5, 10);

    // abort+pause at count 4 -> IDLE with everything cleared
    start(1'b0, 8'd9);
    for (int i = 0; i < 4; i++) idle();
    chk("pre_abort_count", int'(bus.count), 4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("abort_out", int'({bus.count, bus.busy, bus.done, bus.tick}), 0);

    // go+abort together in DONE -> IDLE
    start(1'b0, 8'd1);
    wait_done(10, lat);
    chk("t1_lat", lat, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4);
    chk("go_abort_out", int'({bus.busy, bus.done}), 0);

    // T=0 one-shot: done after the first edge
    start(1'b0, 8'd0);
    wait_done(5, lat);
    chk("t0_lat", lat, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // T=255 periodic: reaches all-ones, ticks, reloads to 0, never done
    start(1'b1, 8'd255);
    for (int i = 1; i <= 256; i++) begin
      idle();
      if (i == 255) chk("max_count", int'(bus.count), 255);
    end
    chk("max_tick", int'(bus.tick), 1);
    chk("max_reload", int'(bus.count), 0);
    chk("max_no_done", int'(bus.done), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // go with a new load_val while busy is ignored; original T=6 honoured
    start(1'b0, 8'd6);
    idle(); idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    wait_done(20, lat);
    chk("busy_go_lat", lat + 3, 7);

    // Mid-run reset
    start(1'b1, 8'd20);
    for (int i = 0; i < 5; i++) idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("midrst_out", int'({bus.count, bus.busy, bus.done, bus.tick}), 0);
    idle();

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 5) == 0),
           1'($urandom),
           t);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
